// File: rtl/draw_scheduler.sv
// Frame-level draw scheduler: walks a latched client mask in ascending order, giving each
// client a go/ack handshake and exclusive use of the registered VGA write port.
module draw_scheduler #(
   parameter logic [15:0] TIMEOUT = 16'd8191
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        frame_tick,
   input  logic        enable,
   input  logic [3:0]  client_mask,
   input  logic        clear_err,
   output logic [3:0]  client_go,
   output logic [3:0]  client_ack,
   input  logic [3:0]  client_done,
   input  logic [3:0]  client_we,
   input  logic [31:0] client_x,
   input  logic [27:0] client_y,
   input  logic [11:0] client_color,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_color,
   output logic        vga_we,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun,
   output logic        timeout_err,
   output logic [1:0]  timeout_idx
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_GO        = 3'd1;
   localparam logic [2:0] S_WAIT_DONE = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_FRAME_END = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  vga_x_q, vga_x_d;
   logic [6:0]  vga_y_q, vga_y_d;
   logic [2:0]  vga_color_q, vga_color_d;
   logic        vga_we_q, vga_we_d;
   logic        overrun_q, overrun_d;
   logic        timeout_err_q, timeout_err_d;
   logic [1:0]  timeout_idx_q, timeout_idx_d;

   logic [7:0]  grant_x;
   logic [6:0]  grant_y;
   logic [2:0]  grant_color;
   logic [2:0]  next_sel;
   logic [3:0]  idx_onehot;
   logic        timeout_set;
   logic        overrun_set;

   function automatic logic [1:0] lowest_bit(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Returns {found, index} of the lowest set mask bit strictly above cur.
   function automatic logic [2:0] next_bit(input logic [3:0] m, input logic [1:0] cur);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   always_comb begin
      grant_x     = client_x[7:0];
      grant_y     = client_y[6:0];
      grant_color = client_color[2:0];
      case (idx_q)
         2'd1: begin
            grant_x     = client_x[15:8];
            grant_y     = client_y[13:7];
            grant_color = client_color[5:3];
         end
         2'd2: begin
            grant_x     = client_x[23:16];
            grant_y     = client_y[20:14];
            grant_color = client_color[8:6];
         end
         2'd3: begin
            grant_x     = client_x[31:24];
            grant_y     = client_y[27:21];
            grant_color = client_color[11:9];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mask_d        = mask_q;
      cnt_d         = cnt_q;
      vga_x_d       = vga_x_q;
      vga_y_d       = vga_y_q;
      vga_color_d   = vga_color_q;
      vga_we_d      = 1'b0;
      overrun_d     = overrun_q;
      timeout_err_d = timeout_err_q;
      timeout_idx_d = timeout_idx_q;
      timeout_set   = 1'b0;
      overrun_set   = frame_tick && (state_q != S_IDLE);
      next_sel      = next_bit(mask_q, idx_q);

      case (state_q)
         S_IDLE: begin
            if (frame_tick && enable) begin
               mask_d  = client_mask;
               idx_d   = lowest_bit(client_mask);
               state_d = (client_mask == 4'd0) ? S_FRAME_END : S_GO;
            end
         end
         S_GO: begin
            cnt_d   = 16'd0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            vga_we_d = client_we[idx_q];
            if (client_we[idx_q]) begin
               vga_x_d     = grant_x;
               vga_y_d     = grant_y;
               vga_color_d = grant_color;
            end
            // Done is tested first so a done arriving on the last allowed cycle is not an error.
            if (client_done[idx_q]) begin
               state_d = S_RELEASE;
            end else if (cnt_q == TIMEOUT - 16'd1) begin
               timeout_set   = 1'b1;
               timeout_idx_d = idx_q;
               state_d       = S_RELEASE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RELEASE: begin
            if (next_sel[2]) begin
               idx_d   = next_sel[1:0];
               state_d = S_GO;
            end else begin
               state_d = S_FRAME_END;
            end
         end
         S_FRAME_END: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (overrun_set) overrun_d = 1'b1;
      else if (clear_err) overrun_d = 1'b0;

      if (timeout_set) timeout_err_d = 1'b1;
      else if (clear_err) timeout_err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         idx_q         <= 2'd0;
         mask_q        <= 4'd0;
         cnt_q         <= 16'd0;
         vga_x_q       <= 8'd0;
         vga_y_q       <= 7'd0;
         vga_color_q   <= 3'd0;
         vga_we_q      <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         timeout_idx_q <= 2'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         cnt_q         <= cnt_d;
         vga_x_q       <= vga_x_d;
         vga_y_q       <= vga_y_d;
         vga_color_q   <= vga_color_d;
         vga_we_q      <= vga_we_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         timeout_idx_q <= timeout_idx_d;
      end
   end

   // Pulses are decoded from the registered state, so they are one cycle wide and one-hot.
   assign idx_onehot  = 4'b0001 << idx_q;
   assign client_go   = (state_q == S_GO)      ? idx_onehot : 4'd0;
   assign client_ack  = (state_q == S_RELEASE) ? idx_onehot : 4'd0;
   assign busy        = (state_q != S_IDLE);
   assign frame_done  = (state_q == S_FRAME_END);
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_color   = vga_color_q;
   assign vga_we      = vga_we_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;
   assign timeout_idx = timeout_idx_q;

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd8191, the maximum number of cycles a client may hold the grant.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port frame_tick  input  1  one-cycle frame-start pulse.
REQ-005 SHALL have port enable  input  1  when 0, frame_tick does not start a frame.
REQ-006 SHALL have port client_mask  input  4  bit i=1 means client i is drawn this frame.
REQ-007 SHALL have port clear_err  input  1  clears the sticky error flags.
REQ-008 SHALL have port client_go  output  4  one-hot start pulse to client i.
REQ-009 SHALL have port client_ack  output  4  one-hot release pulse to client i, returning it from its DONE state to WAIT.
REQ-010 SHALL have port client_done  input  4  level, client i has finished drawing.
REQ-011 SHALL have port client_we  input  4  pixel write enable from client i.
REQ-012 SHALL have port client_x  input  32  packed 4x8, client i on bits [8i+7:8i].
REQ-013 SHALL have port client_y  input  28  packed 4x7, client i on bits [7i+6:7i].
REQ-014 SHALL have port client_color  input  12  packed 4x3, client i on bits [3i+2:3i].
REQ-015 SHALL have ports vga_x  output  8, vga_y  output  7, vga_color  output  3, vga_we  output  1  registered shared VGA write port.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse when a frame finishes.
REQ-018 SHALL have ports overrun  output  1, timeout_err  output  1, timeout_idx  output  2  sticky error flags and the index of the last client that timed out.

Function
REQ-019 SHALL implement the states IDLE, GO, WAIT_DONE, RELEASE and FRAME_END, plus a 2-bit index register idx and a latched 4-bit mask register.
REQ-020 SHALL, in IDLE, when frame_tick=1 and enable=1, latch client_mask and set idx to the lowest set mask bit, then move to GO.
REQ-021 SHALL, in the same case with a latched mask of 0, move straight to FRAME_END.
REQ-022 SHALL, in GO, drive client_go[idx]=1 for exactly one cycle, then move to WAIT_DONE.
REQ-023 SHALL, in WAIT_DONE, grant the VGA port to client idx: next cycle vga_x/vga_y/vga_color equal that client's fields and vga_we equals client_we[idx] (1-cycle latency).
REQ-024 SHALL drive vga_we=0 in every other state and ignore non-granted clients' client_we.
REQ-025 SHALL hold vga_x, vga_y and vga_color at their last value while vga_we=0.
REQ-026 SHALL, in WAIT_DONE, move to RELEASE when client_done[idx]=1.
REQ-027 SHALL count cycles spent in WAIT_DONE starting from 0; when the count reaches TIMEOUT without done, set timeout_err, load timeout_idx=idx and move to RELEASE.
REQ-028 SHALL, in RELEASE, drive client_ack[idx]=1 for one cycle, then advance idx to the next higher set mask bit and enter GO, or enter FRAME_END if none remains.
REQ-029 SHALL give priority to done when done and timeout occur in the same cycle: no error is flagged.
REQ-030 SHALL, in FRAME_END, pulse frame_done for one cycle and return to IDLE.
REQ-031 SHALL set overrun when frame_tick=1 in any state other than IDLE; that tick is otherwise ignored.
REQ-032 SHALL clear overrun and timeout_err on clear_err=1; a set request in the same cycle wins.
REQ-033 SHALL ignore client_mask changes mid-frame and act only on the latched mask.
REQ-034 SHALL keep all client_go and client_ack bits mutually exclusive; at most one bit is high per cycle.

Reset
REQ-035 SHALL, on resetn=0 (asynchronous, mid-operation included), force state IDLE and idx=0, with mask, the timeout counter, client_go, client_ack, vga_x, vga_y, vga_color, vga_we, busy, frame_done, overrun, timeout_err and timeout_idx all 0.

Verification
REQ-036 SHALL check: mask=4'b1111 with each client asserting done 5 cycles after go -> go/ack pulses in the order 0,1,2,3, then frame_done one cycle after the last ack.
REQ-037 SHALL check: mask=4'b0101 -> only clients 0 and 2 receive go; clients 1 and 3 see no go or ack.
REQ-038 SHALL check: client 1 never asserts done with TIMEOUT=20 -> ack[1] after 20 WAIT_DONE cycles, timeout_err=1, timeout_idx=1, then the frame completes.
REQ-039 SHALL check: client 2 writes (x=50, y=10, color=3'b111) while client 0 also has client_we=1 -> the VGA port shows only client 2's pixel, one cycle later.
REQ-040 SHALL check: frame_tick while busy -> overrun=1 and no restart; clear_err -> overrun=0.
REQ-041 SHALL check: resetn pulsed low during WAIT_DONE -> all outputs 0 immediately, and a new frame_tick starts again at client 0.
